// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: computes (a - b - bin) mod 2^WIDTH one bit per clock,
//   LSB first, through a single full-subtractor cell with a registered borrow.
//
// Parameters
//   WIDTH  operand width in bits (2..32)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  begin a subtraction (accepted in IDLE or DONE)
//   a, b   minuend / subtrahend, captured on the accepting edge
//   bin    borrow in, captured on the accepting edge
//   busy   high while bits are being processed
//   done   one-cycle pulse when diff/bout take a new value
//   diff   result, held until the next completion
//   bout   borrow out (1 iff a < b + bin, unsigned)
//   ovf    two's-complement overflow; only present when the macro
//          SERIAL_SUB_OVERFLOW_EN is defined
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // full-subtractor cell on the current LSBs
  logic ai, bi, d_bit, br_nxt;

`ifdef SERIAL_SUB_OVERFLOW_EN
  // operand sign bits are shifted out of the shift registers, so keep them
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    ai     = a_sh_q[0];
    bi     = b_sh_q[0];
    d_bit  = ai ^ bi ^ br_q;
    br_nxt = (~ai & bi) | (~(ai ^ bi) & br_q);

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts start too, giving back-to-back operation
        if (start) begin
          state_d = BUSY;
          cnt_d   = '0;
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          res_d   = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // start is ignored here; operands in flight are untouched
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_nxt;
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // d_bit is the result MSB on the final bit
          ovf_d   = (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // outputs registered from the next state so they align with it
    busy_d = (state_d == BUSY);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule
